// File: rtl/vx_tcu_pkg.sv
// Shared types and constants for the TCU micro-op sequencer.
package vx_tcu_pkg;

  localparam int TCU_STEP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tcu_seq_state_e;

  // Warp id width; a single-warp build still carries a one-bit id.
  function automatic int wid_bits(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage

// File: rtl/vx_tcu_sequencer_if.sv
// Command, micro-op, response and completion signals of the TCU sequencer.
// The master modport is the sequencer's view; slave is the surrounding core.
interface vx_tcu_sequencer_if #(
  parameter int NUM_WARPS = 4
) ();
  import vx_tcu_pkg::*;

  localparam int WID_W = wid_bits(NUM_WARPS);

  logic                  req_valid;
  logic                  req_ready;
  logic [WID_W-1:0]      req_wid;
  logic [TCU_STEP_W-1:0] req_m_cnt;
  logic [TCU_STEP_W-1:0] req_n_cnt;
  logic [TCU_STEP_W-1:0] req_k_cnt;

  logic                  uop_valid;
  logic                  uop_ready;
  logic [WID_W-1:0]      uop_wid;
  logic [TCU_STEP_W-1:0] uop_step_m;
  logic [TCU_STEP_W-1:0] uop_step_n;
  logic [TCU_STEP_W-1:0] uop_step_k;
  logic                  uop_last;

  logic                  rsp_fire;

  logic                  cmp_valid;
  logic                  cmp_ready;
  logic [WID_W-1:0]      cmp_wid;

  modport master (
    input  req_valid, req_wid, req_m_cnt, req_n_cnt, req_k_cnt,
    output req_ready,
    output uop_valid, uop_wid, uop_step_m, uop_step_n, uop_step_k, uop_last,
    input  uop_ready,
    input  rsp_fire,
    output cmp_valid, cmp_wid,
    input  cmp_ready
  );

  modport slave (
    output req_valid, req_wid, req_m_cnt, req_n_cnt, req_k_cnt,
    input  req_ready,
    input  uop_valid, uop_wid, uop_step_m, uop_step_n, uop_step_k, uop_last,
    output uop_ready,
    output rsp_fire,
    input  cmp_valid, cmp_wid,
    output cmp_ready
  );

endinterface

// File: rtl/vx_tcu_credit_cnt.sv
// Tracks micro-ops in flight inside the TCU core; a response arriving with
// nothing outstanding is stale (e.g. from before a reset) and is dropped.
module vx_tcu_credit_cnt #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [CNT_W-1:0] count;
  logic             dec_ok;

  assign dec_ok = dec && (count != '0);
  assign full   = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty  = (count == '0);

  // Count up on issue, down on accepted result, hold when both coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec_ok) begin
      count <= count + 1'b1;
    end else if (!inc && dec_ok) begin
      count <= count - 1'b1;
    end
  end

  spurious_rsp_a : assert property (@(posedge clk) disable iff (!reset) !(dec && empty));

endmodule

// File: rtl/vx_tcu_sequencer.sv
// Expands one MMA command into (m+1)*(n+1)*(k+1) micro-ops, ordered k outer,
// m middle, n inner, throttled by a credit count of results still in flight.
module vx_tcu_sequencer
  import vx_tcu_pkg::*;
#(
  parameter int NUM_WARPS       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                reset,
  vx_tcu_sequencer_if.master  bus,
  output logic                busy
);

  localparam int WID_W = wid_bits(NUM_WARPS);

  tcu_seq_state_e        state;
  logic [WID_W-1:0]      wid_q;
  logic [TCU_STEP_W-1:0] m_cnt;
  logic [TCU_STEP_W-1:0] n_cnt;
  logic [TCU_STEP_W-1:0] k_cnt;
  logic [TCU_STEP_W-1:0] step_m;
  logic [TCU_STEP_W-1:0] step_n;
  logic [TCU_STEP_W-1:0] step_k;

  logic credit_full;
  logic credit_empty;
  logic uop_fire;
  logic n_wrap;
  logic m_wrap;
  logic at_last;

  assign n_wrap  = (step_n == n_cnt);
  assign m_wrap  = (step_m == m_cnt);
  assign at_last = n_wrap && m_wrap && (step_k == k_cnt);

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.uop_valid  = (state == ST_ISSUE) && !credit_full;
  assign bus.uop_wid    = wid_q;
  assign bus.uop_step_m = step_m;
  assign bus.uop_step_n = step_n;
  assign bus.uop_step_k = step_k;
  assign bus.uop_last   = (state == ST_ISSUE) && at_last;
  assign bus.cmp_valid  = (state == ST_DONE);
  assign bus.cmp_wid    = wid_q;
  assign busy           = (state != ST_IDLE);

  assign uop_fire = bus.uop_valid && bus.uop_ready;

  vx_tcu_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (uop_fire),
    .dec   (bus.rsp_fire),
    .full  (credit_full),
    .empty (credit_empty)
  );

  // Command FSM plus the k/m/n step walker that feeds the micro-op fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      wid_q  <= '0;
      m_cnt  <= '0;
      n_cnt  <= '0;
      k_cnt  <= '0;
      step_m <= '0;
      step_n <= '0;
      step_k <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            wid_q  <= bus.req_wid;
            m_cnt  <= bus.req_m_cnt;
            n_cnt  <= bus.req_n_cnt;
            k_cnt  <= bus.req_k_cnt;
            step_m <= '0;
            step_n <= '0;
            step_k <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (uop_fire) begin
            if (at_last) begin
              state <= ST_DRAIN;
            end else if (!n_wrap) begin
              step_n <= step_n + 1'b1;
            end else begin
              step_n <= '0;
              if (!m_wrap) begin
                step_m <= step_m + 1'b1;
              end else begin
                step_m <= '0;
                step_k <= step_k + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (credit_empty) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.cmp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_tcu_sequencer.sv
// Directed bench for vx_tcu_sequencer: table of whole commands plus
// hand-written single-step, credit-stall and mid-command reset sequences.
module tb_vx_tcu_sequencer;

  localparam int NUM_WARPS = 4;
  localparam int MAX_OUT   = 8;

  typedef struct {
    int wid;
    int m;
    int n;
    int k;
    bit ready_rand;
    bit rsp_rand;
    int exp_uops;
  } vec_t;

  logic clk;
  logic reset;
  logic busy;

  int n_compared  = 0;
  int n_mismatched = 0;

  vx_tcu_sequencer_if #(.NUM_WARPS(NUM_WARPS)) bus ();

  vx_tcu_sequencer #(
    .NUM_WARPS       (NUM_WARPS),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Present one command for a single cycle; called just after a negedge.
  task automatic apply_stimulus(input int wid, input int m, input int n, input int k);
    check_output("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wid   = 2'(wid);
    bus.req_m_cnt = 4'(m);
    bus.req_n_cnt = 4'(n);
    bus.req_k_cnt = 4'(k);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Expected fields of micro-op number idx in k-outer, m, n-inner order.
  task automatic check_uop(input int idx, input int m, input int n, input int k, input int wid);
    int en;
    int em;
    int total;
    en    = n + 1;
    em    = m + 1;
    total = en * em * (k + 1);
    check_output($sformatf("uop%0d_valid", idx), 32'(bus.uop_valid), 32'd1);
    check_output($sformatf("uop%0d_n", idx), 32'(bus.uop_step_n), 32'(idx % en));
    check_output($sformatf("uop%0d_m", idx), 32'(bus.uop_step_m), 32'((idx / en) % em));
    check_output($sformatf("uop%0d_k", idx), 32'(bus.uop_step_k), 32'(idx / (en * em)));
    check_output($sformatf("uop%0d_last", idx), 32'(bus.uop_last), (idx == total - 1) ? 32'd1 : 32'd0);
    check_output($sformatf("uop%0d_wid", idx), 32'(bus.uop_wid), 32'(wid));
  endtask

  // Called at the negedge whose following posedge retires the final result.
  task automatic finish_cmd(input int wid);
    tick();
    bus.rsp_fire = 1'b0;
    check_output("cmp_early", 32'(bus.cmp_valid), 32'd0);
    check_output("busy_drain", 32'(busy), 32'd1);
    tick();
    check_output("cmp_valid", 32'(bus.cmp_valid), 32'd1);
    check_output("cmp_wid", 32'(bus.cmp_wid), 32'(wid));
    check_output("req_ready_done", 32'(bus.req_ready), 32'd0);
    tick();
    check_output("cmp_hold", 32'(bus.cmp_valid), 32'd1);
    bus.cmp_ready = 1'b1;
    tick();
    bus.cmp_ready = 1'b0;
    check_output("cmp_cleared", 32'(bus.cmp_valid), 32'd0);
    check_output("busy_idle", 32'(busy), 32'd0);
    check_output("req_ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_vector(input vec_t v);
    int total;
    int issued;
    int out_m;
    int dut_fires;
    int lasts;
    bit exp_valid;
    bit rdy;
    bit rsp;
    bit prev_stall;
    bit done;
    logic [11:0] prev_fields;
    total = (v.m + 1) * (v.n + 1) * (v.k + 1);
    issued = 0; out_m = 0; dut_fires = 0; lasts = 0;
    prev_stall = 1'b0; done = 1'b0; prev_fields = '0;
    apply_stimulus(v.wid, v.m, v.n, v.k);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_valid = (issued < total) && (out_m < MAX_OUT);
      check_output("uop_valid", 32'(bus.uop_valid), 32'(exp_valid));
      if (exp_valid) check_uop(issued, v.m, v.n, v.k, v.wid);
      if (prev_stall)
        check_output("stall_hold", 32'({bus.uop_step_k, bus.uop_step_m, bus.uop_step_n}), 32'(prev_fields));
      rdy = v.ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rsp = (out_m > 0) && (!v.rsp_rand || ($urandom_range(0, 1) == 1));
      bus.uop_ready = rdy;
      bus.rsp_fire  = rsp;
      if (bus.uop_valid && rdy) begin
        dut_fires++;
        if (bus.uop_last) lasts++;
      end
      prev_stall  = exp_valid && !rdy;
      prev_fields = {bus.uop_step_k, bus.uop_step_m, bus.uop_step_n};
      issued = issued + int'(exp_valid && rdy);
      out_m  = out_m + int'(exp_valid && rdy) - int'(rsp);
      if (issued == total && out_m == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL vec_timeout: got no completion, expected %0d uops", total);
      bus.rsp_fire  = 1'b0;
      bus.uop_ready = 1'b0;
    end else begin
      check_output("uop_count", 32'(dut_fires), 32'(v.exp_uops));
      check_output("last_count", 32'(lasts), 32'd1);
      finish_cmd(v.wid);
    end
    bus.uop_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int fires;

    vecs[0] = '{wid: 1, m: 0, n: 0, k: 0, ready_rand: 0, rsp_rand: 0, exp_uops: 1};
    vecs[1] = '{wid: 2, m: 1, n: 1, k: 1, ready_rand: 0, rsp_rand: 0, exp_uops: 8};
    vecs[2] = '{wid: 3, m: 2, n: 1, k: 0, ready_rand: 1, rsp_rand: 1, exp_uops: 6};
    vecs[3] = '{wid: 0, m: 1, n: 2, k: 3, ready_rand: 1, rsp_rand: 1, exp_uops: 24};
    vecs[4] = '{wid: 1, m: 3, n: 0, k: 1, ready_rand: 0, rsp_rand: 1, exp_uops: 8};
    vecs[5] = '{wid: 2, m: 0, n: 3, k: 3, ready_rand: 1, rsp_rand: 0, exp_uops: 16};

    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_wid = '0;
    bus.req_m_cnt = '0; bus.req_n_cnt = '0; bus.req_k_cnt = '0;
    bus.uop_ready = 1'b0; bus.rsp_fire = 1'b0; bus.cmp_ready = 1'b0;

    tick();
    tick();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_uop_valid", 32'(bus.uop_valid), 32'd0);
    check_output("rst_cmp_valid", 32'(bus.cmp_valid), 32'd0);
    reset = 1'b1;
    tick();
    check_output("rel_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rel_busy", 32'(busy), 32'd0);

    // Single step, result returned three cycles after the micro-op.
    bus.uop_ready = 1'b1;
    apply_stimulus(3, 0, 0, 0);
    check_uop(0, 0, 0, 0, 3);
    tick();
    check_output("ss_valid_after", 32'(bus.uop_valid), 32'd0);
    check_output("ss_busy", 32'(busy), 32'd1);
    tick();
    tick();
    bus.rsp_fire = 1'b1;
    finish_cmd(3);
    bus.uop_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i]);
    end

    // Credit stall: 16 micro-ops, no results, then release one by one.
    bus.uop_ready = 1'b1;
    apply_stimulus(2, 0, 3, 3);
    fires = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.uop_valid) begin
        check_uop(fires, 0, 3, 3, 2);
        fires++;
      end
      tick();
    end
    check_output("stall_fires", 32'(fires), 32'd8);
    check_output("stall_valid", 32'(bus.uop_valid), 32'd0);
    for (int r = 0; r < 2; r++) begin
      bus.rsp_fire = 1'b1;
      tick();
      bus.rsp_fire = 1'b0;
      check_uop(fires, 0, 3, 3, 2);
      fires++;
      tick();
      check_output("release_one", 32'(bus.uop_valid), 32'd0);
    end
    bus.rsp_fire = 1'b1;
    tick();
    for (int idx = 10; idx < 16; idx++) begin
      check_uop(idx, 0, 3, 3, 2);
      tick();
    end
    check_output("stall_done_valid", 32'(bus.uop_valid), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    finish_cmd(2);
    bus.uop_ready = 1'b0;

    // Reset while issuing: drop the command silently.
    bus.uop_ready = 1'b1;
    apply_stimulus(1, 1, 1, 1);
    tick();
    tick();
    tick();
    check_uop(3, 1, 1, 1, 1);
    reset = 1'b0;
    #1;
    check_output("mid_rst_uop_valid", 32'(bus.uop_valid), 32'd0);
    check_output("mid_rst_uop_last", 32'(bus.uop_last), 32'd0);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_cmp", 32'(bus.cmp_valid), 32'd0);
    check_output("mid_rst_step", 32'({bus.uop_step_k, bus.uop_step_m, bus.uop_step_n}), 32'd0);
    bus.uop_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_output("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("post_rst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check_output("post_rst_no_cmp", 32'(bus.cmp_valid), 32'd0);
      tick();
    end

    run_vector(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/vx_tcu_sequencer.md
VX_TCU_SEQUENCER -- requirements
Module: VX_tcu_sequencer

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp ids.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, max micro-ops in flight inside the TCU core (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid / req_ready  in/out  1  MMA command handshake.
REQ-006 SHALL have port req_wid  in  log2(NUM_WARPS)  warp of command.
REQ-007 SHALL have ports req_m_cnt, req_n_cnt, req_k_cnt  in  4 each  step counts minus one (0 => 1 step).
REQ-008 SHALL have port uop_valid / uop_ready  out/in  1  micro-op handshake to TCU core execute port.
REQ-009 SHALL have ports uop_wid, uop_step_m, uop_step_n, uop_step_k, uop_last  out  log2(NUM_WARPS),4,4,4,1  micro-op fields; uop_last marks final micro-op.
REQ-010 SHALL have port rsp_fire  in  1  one TCU core result accepted this cycle.
REQ-011 SHALL have port cmp_valid / cmp_ready, cmp_wid  out/in, out  1, log2(NUM_WARPS)  command completion.
REQ-012 SHALL have port busy  out  1  state != IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-014 SHALL assert req_ready only in IDLE; req fire latches wid and counts, clears step counters, enters ISSUE.
REQ-015 SHALL in ISSUE assert uop_valid iff outstanding < MAX_OUTSTANDING; uop fields driven from registers, stable while uop_valid && !uop_ready.
REQ-016 SHALL iterate order k outermost, m middle, n innermost; n wraps at n_cnt to 0 and increments m; m wraps and increments k.
REQ-017 SHALL assert uop_last when step_k==k_cnt && step_m==m_cnt && step_n==n_cnt; uop fire with uop_last moves to DRAIN.
REQ-018 SHALL maintain outstanding counter: +1 on uop fire, -1 on rsp_fire, unchanged when both in same cycle; width log2(MAX_OUTSTANDING)+1.
REQ-019 SHALL in DRAIN wait until outstanding==0 (including same-cycle final rsp_fire result counted next cycle), then enter DONE.
REQ-020 SHALL in DONE assert cmp_valid with cmp_wid; on cmp_ready return to IDLE; cmp_valid held until accepted.
REQ-021 SHALL total micro-ops per command = (m_cnt+1)*(n_cnt+1)*(k_cnt+1); single-step command (all 0) issues exactly one uop with uop_last=1.
REQ-022 SHALL ignore rsp_fire when outstanding==0 (no underflow); flag via assertion in simulation.
REQ-023 SHALL issue at most one uop per cycle; back-to-back fires when uop_ready high and credits available (full throughput).
REQ-024 SHALL not accept a new command before cmp handshake of the current one completes.

Reset
REQ-025 SHALL on reset low asynchronously force state IDLE, outstanding 0, step counters 0, all valid outputs 0, busy 0, req_ready 1 after release.
REQ-026 SHALL on reset mid-command drop the command without cmp_valid; in-flight core results after release are ignored per REQ-022.

Structure
REQ-027 SHALL place FSM state enum and step-count width constant (TCU_STEP_W=4) in VX_tcu_pkg.
REQ-028 SHALL implement outstanding credit tracking as sub-module VX_tcu_credit_cnt (inc, dec, full, empty); remaining logic flat.

Verification
REQ-029 SHALL test single-step: counts 0/0/0, uop_ready=1, rsp_fire 3 cycles later -> one uop (m=n=k=0, last=1), cmp_valid 1 cycle after rsp, wid echoed.
REQ-030 SHALL test ordering: m_cnt=1,n_cnt=1,k_cnt=1 -> 8 uops in order (k,m,n) 000,001,010,011,100,101,110,111; last only on 8th.
REQ-031 SHALL test credit stall: MAX_OUTSTANDING=8, counts 0/3/3 (16 uops), no rsp_fire -> exactly 8 uops then uop_valid=0; each rsp_fire releases one uop.
REQ-032 SHALL test backpressure: uop_ready toggled randomly -> uop fields stable while stalled, no duplicate or skipped step.
REQ-033 SHALL test simultaneous uop fire and rsp_fire with outstanding=MAX_OUTSTANDING-1 -> outstanding unchanged, uop_valid stays high.
REQ-034 SHALL test reset asserted in ISSUE after 3 uops -> all outputs 0 immediately, req_ready=1 after release, no cmp_valid.
